// File: rtl/imem_boot_loader_if.sv
// Bundles the program-load stream, loader status and the core fetch port between
// imem_boot_loader and whatever drives it (core plus boot host).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic [ADDR_W:0]   load_count;
  logic              busy;
  logic              core_rst_n;
  logic [31:0]       pcF;
  logic [31:0]       instrF;
  logic              fetch_err;

  modport master (
    output load_start, load_valid, load_data, load_last, pcF,
    input  load_ready, load_count, busy, core_rst_n, instrF, fetch_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, pcF,
    output load_ready, load_count, busy, core_rst_n, instrF, fetch_err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory for the pipeline core's fetch port: clears itself to NOP, takes a
// valid/ready program stream, then releases the core and serves zero-latency fetches.
module imem_boot_loader #(
  parameter int          DEPTH  = 256,
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [31:0]       mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              fetch_err_q, fetch_err_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  logic              run;
  logic              fetch_ok;
  logic [ADDR_W-1:0] raddr;

  assign run      = (state_q == RUN) && !rst;
  assign raddr    = bus.pcF[ADDR_W+1:2];
  assign fetch_ok = (bus.pcF[1:0] == 2'b00) && (bus.pcF[31:ADDR_W+2] == '0);

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    load_count_d = load_count_q;
    fetch_err_d  = fetch_err_q;
    we           = 1'b0;
    waddr        = clr_idx_q;
    wdata        = NOP;
    if (bus.load_start) begin
      // A reprogram request preempts everything, including a coincident handshake.
      state_d      = CLEAR;
      clr_idx_d    = '0;
      load_count_d = '0;
      fetch_err_d  = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          we        = 1'b1;
          waddr     = clr_idx_q;
          wdata     = NOP;
          clr_idx_d = clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == LAST_IDX) state_d = LOAD;
        end
        LOAD: begin
          if (bus.load_valid) begin
            we           = 1'b1;
            waddr        = load_count_q[ADDR_W-1:0];
            wdata        = bus.load_data;
            load_count_d = load_count_q + (ADDR_W+1)'(1);
            if (bus.load_last || (load_count_q[ADDR_W-1:0] == LAST_IDX)) state_d = RUN;
          end
        end
        RUN: begin
          if (!fetch_ok) fetch_err_d = 1'b1;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      load_count_q <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      load_count_q <= load_count_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Storage carries no reset; contents become defined once the first CLEAR pass ends.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign bus.load_ready = (state_q == LOAD) && !rst;
  assign bus.busy       = !run;
  assign bus.core_rst_n = run;
  assign bus.load_count = load_count_q;
  assign bus.fetch_err  = fetch_err_q;
  assign bus.instrF     = (run && fetch_ok) ? mem[raddr] : NOP;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: clear timing, streamed loads with and without
// gaps, full-depth load, fetch error flag, and reset / reprogram wiping.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.DEPTH(256), .ADDR_W(8), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input int gap);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  // Counts edges from the current point until load_ready shows; expects a full clear pass.
  task automatic wait_load(input string name);
    int  n;
    logic side_bad;
    n = 0;
    side_bad = 1'b0;
    while (bus.load_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
      if (bus.load_ready !== 1'b1 && (bus.busy !== 1'b1 || bus.core_rst_n !== 1'b0))
        side_bad = 1'b1;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL %s clear_cycles actual=%0d required=256", name, n);
    end
    checks++;
    if (side_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/core_rst_n during clear actual=bad required=busy=1,core_rst_n=0", name);
    end
  endtask

  task automatic check_fetch(input string name, input logic [31:0] pc, input logic [31:0] exp);
    bus.pcF = pc;
    #1;
    checks++;
    if (bus.instrF !== exp) begin
      errors++;
      $display("FAIL %s pcF=%h instrF actual=%h required=%h", name, pc, bus.instrF, exp);
    end
  endtask

  task automatic test_reset();
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.instrF !== NOP) begin
      errors++;
      $display("FAIL reset_outputs actual=rdy%b busy%b crn%b instr%h required=rdy0 busy1 crn0 instr%h",
               bus.load_ready, bus.busy, bus.core_rst_n, bus.instrF, NOP);
    end
    step();
    rst = 1'b0;
    wait_load("reset");
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_count !== 9'd0 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d ferr=%b required count=0 ferr=0", bus.load_count, bus.fetch_err);
    end
  endtask

  task automatic load_three(input string name, input int gap);
    send_word(32'h0050_0093, 1'b0, gap);
    send_word(32'h0030_0113, 1'b0, gap);
    checks++;
    if (bus.core_rst_n !== 1'b0 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s mid_load crn=%b rdy=%b required crn=0 rdy=1", name, bus.core_rst_n, bus.load_ready);
    end
    send_word(32'h0020_81B3, 1'b1, 0);
    checks++;
    if (bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.load_ready !== 1'b0 || bus.load_count !== 9'd3) begin
      errors++;
      $display("FAIL %s run_entry crn=%b busy=%b rdy=%b count=%0d required crn=1 busy=0 rdy=0 count=3",
               name, bus.core_rst_n, bus.busy, bus.load_ready, bus.load_count);
    end
    check_fetch(name, 32'd0,  32'h0050_0093);
    check_fetch(name, 32'd4,  32'h0030_0113);
    check_fetch(name, 32'd8,  32'h0020_81B3);
    check_fetch(name, 32'd12, NOP);
  endtask

  task automatic test_load_basic();
    load_three("basic", 0);
  endtask

  task automatic test_gaps();
    pulse_start();
    checks++;
    if (bus.core_rst_n !== 1'b0 || bus.load_count !== 9'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_restart crn=%b count=%0d busy=%b required crn=0 count=0 busy=1",
               bus.core_rst_n, bus.load_count, bus.busy);
    end
    wait_load("gaps");
    load_three("gaps", 2);
  endtask

  task automatic test_full();
    pulse_start();
    wait_load("full");
    for (int i = 0; i < 255; i++) send_word(32'h1000_0000 + 32'(i), 1'b0, 0);
    checks++;
    if (bus.core_rst_n !== 1'b0 || bus.load_count !== 9'd255) begin
      errors++;
      $display("FAIL full_255 crn=%b count=%0d required crn=0 count=255", bus.core_rst_n, bus.load_count);
    end
    send_word(32'h1000_00FF, 1'b0, 0);
    checks++;
    if (bus.core_rst_n !== 1'b1 || bus.load_count !== 9'd256 || bus.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL full_256 crn=%b count=%0d ferr=%b required crn=1 count=256 ferr=0",
               bus.core_rst_n, bus.load_count, bus.fetch_err);
    end
    check_fetch("full", 32'h0000_03FC, 32'h1000_00FF);
    check_fetch("full", 32'h0000_0000, 32'h1000_0000);
    check_fetch("full", 32'h0000_0200, 32'h1000_0080);
  endtask

  task automatic test_fetch_err();
    check_fetch("ferr", 32'h0000_0402, NOP);
    step();
    checks++;
    if (bus.fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_set actual=%b required=1", bus.fetch_err);
    end
    check_fetch("ferr", 32'h0000_0400, NOP);
    step();
    check_fetch("ferr", 32'h0000_0004, 32'h1000_0001);
    step();
    checks++;
    if (bus.fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_sticky actual=%b required=1", bus.fetch_err);
    end
    pulse_start();
    checks++;
    if (bus.fetch_err !== 1'b0 || bus.instrF !== NOP) begin
      errors++;
      $display("FAIL ferr_clear ferr=%b instr=%h required ferr=0 instr=%h", bus.fetch_err, bus.instrF, NOP);
    end
  endtask

  task automatic test_wipe();
    wait_load("wipe");
    send_word(32'hAAAA_0001, 1'b0, 0);
    send_word(32'hAAAA_0002, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.core_rst_n !== 1'b0 || bus.load_count !== 9'd0 || bus.busy !== 1'b1 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL wipe_rst crn=%b count=%0d busy=%b rdy=%b required crn=0 count=0 busy=1 rdy=0",
               bus.core_rst_n, bus.load_count, bus.busy, bus.load_ready);
    end
    wait_load("wipe_rst");
    send_word(32'hABCD_0001, 1'b1, 0);
    check_fetch("wipe_rst", 32'd0, 32'hABCD_0001);
    check_fetch("wipe_rst", 32'd4, NOP);
    pulse_start();
    checks++;
    if (bus.core_rst_n !== 1'b0 || bus.load_count !== 9'd0) begin
      errors++;
      $display("FAIL wipe_start crn=%b count=%0d required crn=0 count=0", bus.core_rst_n, bus.load_count);
    end
    wait_load("wipe_start");
    // Word presented together with load_start must be dropped.
    bus.load_start = 1'b1;
    send_word(32'h5555_5555, 1'b1, 0);
    bus.load_start = 1'b0;
    checks++;
    if (bus.load_count !== 9'd0 || bus.load_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_hs count=%0d rdy=%b busy=%b required count=0 rdy=0 busy=1",
               bus.load_count, bus.load_ready, bus.busy);
    end
    wait_load("wipe_drop");
    send_word(32'h0000_0093, 1'b1, 0);
    check_fetch("wipe_start", 32'd0, 32'h0000_0093);
    check_fetch("wipe_start", 32'd4, NOP);
    check_fetch("misalign", 32'd2, NOP);
    step();
    checks++;
    if (bus.fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_err actual=%b required=1", bus.fetch_err);
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.pcF        = '0;
    step();
    test_reset();
    test_load_basic();
    test_gaps();
    test_full();
    test_fetch_err();
    test_wipe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
